// File: rtl/rgb_gray_stream.sv
// rtl/rgb_gray_stream.sv - handshaked R,G,B byte stream to gray sample converter with row/frame markers
module rgb_gray_stream #(
  parameter int DW = 8,
  parameter int N  = 450,
  parameter int M  = 450
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_eol,
  output logic          out_eof,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  // Column and row counter widths; a one-entry dimension still needs one bit.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  // Working width for the weighted sums. The averaging mode multiplies a
  // three-byte sum (DW+2 bits) by 683 (10 bits), so it needs DW+12 bits to
  // avoid wrapping before the final shift.
  localparam int IW = DW + 12;

  localparam logic [IW-1:0] SAT_MAX = IW'({DW{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [1:0]      phase;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [DW-1:0]   r_q;
  logic [DW-1:0]   g_q;

  logic            in_hs;
  logic            b_hs;
  logic            out_hs;
  logic            last_col;
  logic            last_row;

  logic [IW-1:0]   rw;
  logic [IW-1:0]   gw;
  logic [IW-1:0]   bw;
  logic [IW-1:0]   y_wide;
  logic [DW-1:0]   gray;

  // A B byte may only be taken when the output register is free or draining
  // this same cycle; R and G bytes never touch the output register.
  assign in_ready = (state == S_RUN) && !(phase == 2'd2 && out_valid && !out_ready);

  assign in_hs    = in_valid && in_ready;
  assign b_hs     = in_hs && (phase == 2'd2);
  assign out_hs   = out_valid && out_ready;
  assign last_col = (col == CW'(N - 1));
  assign last_row = (row == RW'(M - 1));

  // Weighted gray value of the held R, G and the B byte on the bus, saturated to DW bits.
  always_comb begin
    rw = IW'(r_q);
    gw = IW'(g_q);
    bw = IW'(in_data);
    y_wide = '0;
    case (mode_q)
      2'd0: y_wide = (rw >> 2) + (rw >> 5) + (gw >> 1) + (gw >> 4) + (bw >> 4) + (bw >> 5);
      2'd1: y_wide = (rw * IW'(77) + gw * IW'(150) + bw * IW'(29) + IW'(128)) >> 8;
      2'd2: y_wide = ((rw + gw + bw) * IW'(683)) >> 11;
      default: y_wide = gw;
    endcase
    gray = (y_wide > SAT_MAX) ? {DW{1'b1}} : y_wide[DW-1:0];
  end

  // Frame sequencing: start latching, byte phase steering, column/row walk and end-of-frame done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mode_q <= 2'd0;
      phase  <= 2'd0;
      col    <= '0;
      row    <= '0;
      r_q    <= '0;
      g_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            phase  <= 2'd0;
            col    <= '0;
            row    <= '0;
            state  <= S_RUN;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
          if (in_hs) begin
            case (phase)
              2'd0: begin
                r_q   <= in_data;
                phase <= 2'd1;
              end
              2'd1: begin
                g_q   <= in_data;
                phase <= 2'd2;
              end
              2'd2: begin
                phase <= 2'd0;
                if (last_col) begin
                  col <= '0;
                  if (last_row) begin
                    row   <= '0;
                    state <= S_DRAIN;
                  end else begin
                    row <= row + RW'(1);
                  end
                end else begin
                  col <= col + CW'(1);
                end
              end
              default: phase <= 2'd0;
            endcase
          end
        end
        S_DRAIN: begin
          if (out_hs) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output sample register: loads on each completed pixel, clears once taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (b_hs) begin
      out_valid <= 1'b1;
      out_data  <= gray;
      out_eol   <= last_col;
      out_eof   <= last_col && last_row;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule
